// File: rtl/oam_dma_controller.sv
// OAM DMA sequencer: a CPU write to FF46 copies DMA_LENGTH bytes from {page, 8'h00}
// into sprite OAM, one byte every CYCLES_PER_BYTE clocks, while fencing the CPU into high RAM.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no transfer; all strobes low
// ST_DELAY | startup wait after the FF46 write, STARTUP_CYCLES clocks
// ST_XFER  | byte loop: read in phase 0, capture at READ_LATENCY, OAM write in last phase
module oam_dma_controller #(
   parameter int DMA_LENGTH      = 160,
   parameter int CYCLES_PER_BYTE = 4,
   parameter int READ_LATENCY    = 1,
   parameter int STARTUP_CYCLES  = 4
) (
   input  logic        iClock,
   input  logic        iReset,
   input  logic [15:0] iCpuAddr,
   input  logic        iCpuWe,
   input  logic [7:0]  iCpuData,
   output logic [7:0]  oDmaReg,
   output logic        oDmaActive,
   output logic        oCpuBusBlock,
   output logic        oBusReadRequest,
   output logic [15:0] oBusAddr,
   input  logic [7:0]  iBusData,
   output logic        oOamWe,
   output logic [7:0]  oOamAddr,
   output logic [7:0]  oOamData
);

   localparam int PW = $clog2(CYCLES_PER_BYTE);
   localparam int DW = (STARTUP_CYCLES > 1) ? $clog2(STARTUP_CYCLES) : 1;
   localparam logic [PW-1:0] PH_CAP   = PW'(READ_LATENCY);
   localparam logic [PW-1:0] PH_LAST  = PW'(CYCLES_PER_BYTE - 1);
   localparam logic [7:0]    IDX_LAST = 8'(DMA_LENGTH - 1);
   localparam logic [DW-1:0] DLY_LOAD = DW'(STARTUP_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DELAY = 2'd1,
      ST_XFER  = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [7:0]    dma_reg_q, dma_reg_d;
   logic [7:0]    page_q, page_d;
   logic [7:0]    index_q, index_d;
   logic [7:0]    data_q, data_d;
   logic [PW-1:0] phase_q, phase_d;
   logic [DW-1:0] delay_q, delay_d;

   logic trigger;
   logic in_xfer;
   logic addr_phase;
   logic write_phase;
   logic hram_addr;

   assign trigger = iCpuWe && (iCpuAddr == 16'hFF46);

   always_comb begin
      state_d   = state_q;
      dma_reg_d = dma_reg_q;
      page_d    = page_q;
      index_d   = index_q;
      data_d    = data_q;
      phase_d   = phase_q;
      delay_d   = delay_q;
      if (trigger) begin
         // Pages E0..FF alias the work-RAM echo, so fetch from C0..DF instead.
         dma_reg_d = iCpuData;
         page_d    = (iCpuData >= 8'hE0) ? (iCpuData & 8'hDF) : iCpuData;
         state_d   = ST_DELAY;
         delay_d   = DLY_LOAD;
         index_d   = 8'h00;
         phase_d   = '0;
         data_d    = 8'h00;
      end else begin
         case (state_q)
            ST_DELAY: begin
               if (delay_q == '0) begin
                  state_d = ST_XFER;
                  index_d = 8'h00;
                  phase_d = '0;
               end else begin
                  delay_d = delay_q - 1'b1;
               end
            end
            ST_XFER: begin
               if (phase_q == PH_CAP) begin
                  data_d = iBusData;
               end
               if (phase_q == PH_LAST) begin
                  phase_d = '0;
                  if (index_q == IDX_LAST) begin
                     state_d = ST_IDLE;
                  end else begin
                     index_d = index_q + 8'd1;
                  end
               end else begin
                  phase_d = phase_q + 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   always_ff @(posedge iClock or negedge iReset) begin
      if (!iReset) begin
         state_q   <= ST_IDLE;
         dma_reg_q <= 8'h00;
         page_q    <= 8'h00;
         index_q   <= 8'h00;
         data_q    <= 8'h00;
         phase_q   <= '0;
         delay_q   <= '0;
      end else begin
         state_q   <= state_d;
         dma_reg_q <= dma_reg_d;
         page_q    <= page_d;
         index_q   <= index_d;
         data_q    <= data_d;
         phase_q   <= phase_d;
         delay_q   <= delay_d;
      end
   end

   assign in_xfer    = (state_q == ST_XFER);
   assign addr_phase = in_xfer && (phase_q <= PH_CAP);
   // A restart landing on the write edge wins: that byte is dropped.
   assign write_phase = in_xfer && (phase_q == PH_LAST) && !trigger;
   assign hram_addr   = (iCpuAddr >= 16'hFF80) && (iCpuAddr <= 16'hFFFE);

   assign oDmaReg         = dma_reg_q;
   assign oDmaActive      = (state_q != ST_IDLE);
   assign oCpuBusBlock    = oDmaActive && !hram_addr && (iCpuAddr != 16'hFF46);
   assign oBusReadRequest = in_xfer && (phase_q == '0);
   assign oBusAddr        = addr_phase ? {page_q, index_q} : 16'h0000;
   assign oOamWe          = write_phase;
   assign oOamAddr        = write_phase ? index_q : 8'h00;
   assign oOamData        = write_phase ? data_q : 8'h00;

endmodule

// File: tb/tb_oam_dma_controller.sv
// Bench for oam_dma_controller: default instance plus a READ_LATENCY=2 / CYCLES_PER_BYTE=5 instance,
// checked against a transfer-schedule model built from trigger times and pages.
module tb_oam_dma_controller;

   localparam int LEN     = 160;
   localparam int CPB     = 4;
   localparam int RL      = 1;
   localparam int STARTUP = 4;
   localparam int CPB2    = 5;
   localparam int RL2     = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic [15:0] cpu_addr;
   logic        cpu_we;
   logic [7:0]  cpu_data;
   logic        sel2;

   logic [7:0]  d1_dma_reg, d1_oam_addr, d1_oam_data, bus_data1;
   logic        d1_active, d1_cpu_block, d1_rd_req, d1_oam_we;
   logic [15:0] d1_bus_addr;
   logic [7:0]  d2_dma_reg, d2_oam_addr, d2_oam_data, bus_data2;
   logic        d2_active, d2_cpu_block, d2_rd_req, d2_oam_we;
   logic [15:0] d2_bus_addr;

   oam_dma_controller dut1 (
      .iClock(clk), .iReset(rst_n), .iCpuAddr(cpu_addr), .iCpuWe(cpu_we & ~sel2),
      .iCpuData(cpu_data), .oDmaReg(d1_dma_reg), .oDmaActive(d1_active),
      .oCpuBusBlock(d1_cpu_block), .oBusReadRequest(d1_rd_req), .oBusAddr(d1_bus_addr),
      .iBusData(bus_data1), .oOamWe(d1_oam_we), .oOamAddr(d1_oam_addr), .oOamData(d1_oam_data)
   );

   oam_dma_controller #(.DMA_LENGTH(LEN), .CYCLES_PER_BYTE(CPB2), .READ_LATENCY(RL2),
                        .STARTUP_CYCLES(STARTUP)) dut2 (
      .iClock(clk), .iReset(rst_n), .iCpuAddr(cpu_addr), .iCpuWe(cpu_we & sel2),
      .iCpuData(cpu_data), .oDmaReg(d2_dma_reg), .oDmaActive(d2_active),
      .oCpuBusBlock(d2_cpu_block), .oBusReadRequest(d2_rd_req), .oBusAddr(d2_bus_addr),
      .iBusData(bus_data2), .oOamWe(d2_oam_we), .oOamAddr(d2_oam_addr), .oOamData(d2_oam_data)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Source memory: byte = addr[7:0] ^ 5A, delivered READ_LATENCY clocks after the address.
   logic [7:0] mem2a_q;
   always @(posedge clk) begin
      bus_data1 <= d1_bus_addr[7:0] ^ 8'h5A;
      mem2a_q   <= d2_bus_addr[7:0] ^ 8'h5A;
      bus_data2 <= mem2a_q;
   end

   int          rd_c[$], wr_c[$], rd2_c[$], wr2_c[$];
   logic [15:0] rd_a[$], rd2_a[$];
   logic [7:0]  wr_i[$], wr_d[$], wr2_i[$], wr2_d[$];
   int          act_cnt, hold_cnt, act2_cnt, hold2_cnt;

   always @(negedge clk) begin
      if (d1_rd_req) begin rd_c.push_back(cyc); rd_a.push_back(d1_bus_addr); end
      if (d1_oam_we) begin wr_c.push_back(cyc); wr_i.push_back(d1_oam_addr); wr_d.push_back(d1_oam_data); end
      if (d1_active) act_cnt++;
      if (d1_bus_addr != 16'h0000) hold_cnt++;
      if (d2_rd_req) begin rd2_c.push_back(cyc); rd2_a.push_back(d2_bus_addr); end
      if (d2_oam_we) begin wr2_c.push_back(cyc); wr2_i.push_back(d2_oam_addr); wr2_d.push_back(d2_oam_data); end
      if (d2_active) act2_cnt++;
      if (d2_bus_addr != 16'h0000) hold2_cnt++;
   end

   // Reference model: each trigger schedules LEN reads/writes; a later trigger cuts the schedule.
   int          tr_c[$];
   logic [7:0]  tr_p[$];
   int          exp_rd_c[$], exp_wr_c[$];
   logic [15:0] exp_rd_a[$];
   logic [7:0]  exp_wr_i[$], exp_wr_d[$];

   task automatic build_expect();
      exp_rd_c.delete(); exp_rd_a.delete();
      exp_wr_c.delete(); exp_wr_i.delete(); exp_wr_d.delete();
      for (int t = 0; t < tr_c.size(); t++) begin
         int stop;
         stop = (t + 1 < tr_c.size()) ? tr_c[t+1] : 32'h7fff_ffff;
         for (int k = 0; k < LEN; k++) begin
            int rc, wc;
            rc = tr_c[t] + STARTUP + k * CPB;
            wc = rc + CPB - 1;
            if (rc < stop) begin
               exp_rd_c.push_back(rc);
               exp_rd_a.push_back({tr_p[t], 8'(k)});
            end
            if (wc < stop - 1) begin
               exp_wr_c.push_back(wc);
               exp_wr_i.push_back(8'(k));
               exp_wr_d.push_back(8'(k) ^ 8'h5A);
            end
         end
      end
   endtask

   function automatic int log_diff();
      int n = 0;
      if (rd_c.size() != exp_rd_c.size()) n++;
      else for (int i = 0; i < rd_c.size(); i++)
         if (rd_c[i] != exp_rd_c[i] || rd_a[i] !== exp_rd_a[i]) n++;
      if (wr_c.size() != exp_wr_c.size()) n++;
      else for (int i = 0; i < wr_c.size(); i++)
         if (wr_c[i] != exp_wr_c[i] || wr_i[i] !== exp_wr_i[i] || wr_d[i] !== exp_wr_d[i]) n++;
      return n;
   endfunction

   function automatic logic blk_model(input logic act, input logic [15:0] a);
      return act && !(a >= 16'hFF80 && a <= 16'hFFFE) && (a != 16'hFF46);
   endfunction

   task automatic clear_logs();
      rd_c.delete(); rd_a.delete(); wr_c.delete(); wr_i.delete(); wr_d.delete();
      rd2_c.delete(); rd2_a.delete(); wr2_c.delete(); wr2_i.delete(); wr2_d.delete();
      tr_c.delete(); tr_p.delete();
      act_cnt = 0; hold_cnt = 0; act2_cnt = 0; hold2_cnt = 0;
   endtask

   // Called #1 after a rising edge; returns the edge number that carried the trigger.
   task automatic cpu_write(input logic [7:0] val, output int t);
      cpu_addr = 16'hFF46; cpu_data = val; cpu_we = 1'b1;
      @(posedge clk); #1;
      t = cyc; cpu_we = 1'b0; cpu_addr = 16'h0000;
      tr_c.push_back(t);
      tr_p.push_back((val >= 8'hE0) ? val - 8'h20 : val);
   endtask

   task automatic step(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic wait_idle1();
      int n = 0;
      while (d1_active && n < 3000) begin step(1); n++; end
      step(2);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; cpu_addr = 16'h0; cpu_we = 1'b0; cpu_data = 8'h0; sel2 = 1'b0;
      clear_logs();
      #22;
      checks++;
      if ({d1_dma_reg, d1_active, d1_cpu_block, d1_rd_req, d1_bus_addr, d1_oam_we, d1_oam_addr, d1_oam_data} !== 44'h0) begin
         errors++; $display("FAIL reset_outputs_dut1: got active=%b we=%b addr=%h reg=%h, want all 0", d1_active, d1_oam_we, d1_bus_addr, d1_dma_reg);
      end
      checks++;
      if ({d2_dma_reg, d2_active, d2_cpu_block, d2_rd_req, d2_bus_addr, d2_oam_we, d2_oam_addr, d2_oam_data} !== 44'h0) begin
         errors++; $display("FAIL reset_outputs_dut2: got active=%b we=%b addr=%h, want all 0", d2_active, d2_oam_we, d2_bus_addr);
      end
      @(posedge clk); #1; rst_n = 1'b1;
      step(3);
   endtask

   task automatic test_basic();
      int t, first, d;
      clear_logs();
      cpu_write(8'hC1, t);
      wait_idle1();
      build_expect();
      d = log_diff();
      checks++;
      if (d != 0) begin errors++; $display("FAIL basic_schedule: %0d diffs (reads %0d/%0d writes %0d/%0d), want 0", d, rd_c.size(), exp_rd_c.size(), wr_c.size(), exp_wr_c.size()); end
      checks++;
      if (act_cnt != STARTUP + LEN * CPB) begin errors++; $display("FAIL basic_active: got %0d clocks, want %0d", act_cnt, STARTUP + LEN * CPB); end
      first = (rd_c.size() > 0) ? rd_c[0] - t : -1;
      checks++;
      if (first != STARTUP) begin errors++; $display("FAIL basic_first_read: got %0d clocks, want %0d", first, STARTUP); end
      checks++;
      if (d1_dma_reg !== 8'hC1) begin errors++; $display("FAIL basic_dma_reg: got %h, want c1", d1_dma_reg); end
      checks++;
      if (hold_cnt != LEN * (RL + 1)) begin errors++; $display("FAIL basic_addr_hold: got %0d clocks, want %0d", hold_cnt, LEN * (RL + 1)); end
   endtask

   task automatic test_echo();
      logic [7:0]  vals[2];
      logic [15:0] exp_a[2];
      int t;
      vals[0] = 8'hE3; vals[1] = 8'hFE;
      exp_a[0] = 16'hC300; exp_a[1] = 16'hDE00;
      for (int i = 0; i < 2; i++) begin
         clear_logs();
         cpu_write(vals[i], t);
         wait_idle1();
         checks++;
         if (rd_a.size() == 0 || rd_a[0] !== exp_a[i]) begin
            errors++; $display("FAIL echo_first_addr: got %h, want %h", (rd_a.size() > 0) ? rd_a[0] : 16'hxxxx, exp_a[i]);
         end
         checks++;
         if (d1_dma_reg !== vals[i]) begin errors++; $display("FAIL echo_dma_reg: got %h, want %h", d1_dma_reg, vals[i]); end
      end
   endtask

   task automatic test_random_pages();
      int t, d;
      logic [7:0] p;
      for (int i = 0; i < 3; i++) begin
         clear_logs();
         p = 8'($urandom_range(1, 255));
         cpu_write(p, t);
         wait_idle1();
         build_expect();
         d = log_diff();
         checks++;
         if (d != 0 || act_cnt != STARTUP + LEN * CPB) begin
            errors++; $display("FAIL random_page_%h: diffs=%0d active=%0d, want 0 and %0d", p, d, act_cnt, STARTUP + LEN * CPB);
         end
         checks++;
         if (d1_dma_reg !== p) begin errors++; $display("FAIL random_dma_reg: got %h, want %h", d1_dma_reg, p); end
      end
   endtask

   task automatic test_restart();
      int t1, t2, d;
      clear_logs();
      cpu_write(8'hC0, t1);
      while (cyc < t1 + STARTUP + 50 * CPB + 2) step(1);
      cpu_write(8'h80, t2);
      wait_idle1();
      build_expect();
      d = log_diff();
      checks++;
      if (d != 0) begin errors++; $display("FAIL restart_schedule: %0d diffs (writes %0d/%0d), want 0", d, wr_c.size(), exp_wr_c.size()); end
      checks++;
      if (act_cnt != (t2 - t1) + STARTUP + LEN * CPB) begin
         errors++; $display("FAIL restart_active: got %0d clocks, want %0d", act_cnt, (t2 - t1) + STARTUP + LEN * CPB);
      end
      checks++;
      if (rd_c.size() < 52 || rd_a[51] !== 16'h8000 || rd_c[51] != t2 + STARTUP) begin
         errors++; $display("FAIL restart_first_read: got %0d reads, want read 51 at 8000 cycle %0d", rd_c.size(), t2 + STARTUP);
      end
      checks++;
      if (wr_i.size() < 51 || wr_i[49] !== 8'd49 || wr_i[50] !== 8'd0) begin
         errors++; $display("FAIL restart_oam_index: got %0d writes, want index 49 then 0", wr_i.size());
      end
   endtask

   task automatic test_coincident();
      int t1, t2, d, k;
      logic [7:0] p1, p2;
      clear_logs();
      k  = $urandom_range(5, 150);
      p1 = 8'($urandom_range(1, 255));
      p2 = 8'($urandom_range(1, 255));
      cpu_write(p1, t1);
      while (cyc < t1 + STARTUP + k * CPB + CPB - 1) step(1);
      cpu_write(p2, t2);
      wait_idle1();
      build_expect();
      d = log_diff();
      checks++;
      if (d != 0 || act_cnt != (t2 - t1) + STARTUP + LEN * CPB) begin
         errors++; $display("FAIL coincident_k%0d: diffs=%0d writes=%0d/%0d active=%0d, want 0", k, d, wr_c.size(), exp_wr_c.size(), act_cnt);
      end
   endtask

   task automatic test_bus_block();
      logic [15:0] addrs[9];
      logic        exp_b[9];
      logic [15:0] a;
      int t;
      addrs = '{16'hC000, 16'hFF85, 16'hFFFE, 16'hFF46, 16'hC000, 16'hFFFF, 16'hFE00, 16'hFF80, 16'hFF7F};
      exp_b = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      clear_logs();
      cpu_write(8'hC5, t);
      for (int i = 0; i < 9; i++) begin
         if (i == 1) step(10);
         cpu_addr = addrs[i];
         @(negedge clk);
         checks++;
         if (d1_cpu_block !== exp_b[i]) begin errors++; $display("FAIL block_%h: got %b, want %b", addrs[i], d1_cpu_block, exp_b[i]); end
         step(1);
      end
      for (int i = 0; i < 16; i++) begin
         a = 16'($urandom);
         if (i[0]) a[15:8] = 8'hFF;
         cpu_addr = a;
         @(negedge clk);
         checks++;
         if (d1_cpu_block !== blk_model(cyc >= t && cyc < t + STARTUP + LEN * CPB, a)) begin
            errors++; $display("FAIL block_rand_%h: got %b, want %b", a, d1_cpu_block, ~d1_cpu_block);
         end
         step(1);
      end
      cpu_addr = 16'h0000;
      wait_idle1();
      checks++;
      if (act_cnt != STARTUP + LEN * CPB) begin errors++; $display("FAIL block_active: got %0d, want %0d", act_cnt, STARTUP + LEN * CPB); end
      for (int i = 0; i < 6; i++) begin
         a = (i < 2) ? 16'hC000 + 16'(i) : 16'($urandom);
         cpu_addr = a;
         @(negedge clk);
         checks++;
         if (d1_cpu_block !== 1'b0) begin errors++; $display("FAIL block_idle_%h: got %b, want 0", a, d1_cpu_block); end
         step(1);
      end
      cpu_addr = 16'h0000;
   endtask

   task automatic test_timing_rl2();
      int t, n, bad_w, bad_r;
      clear_logs();
      sel2 = 1'b1;
      cpu_write(8'h42, t);
      sel2 = 1'b0;
      n = 0;
      while (d2_active && n < 3000) begin step(1); n++; end
      step(2);
      checks++;
      if (act2_cnt != STARTUP + LEN * CPB2) begin errors++; $display("FAIL rl2_active: got %0d, want %0d", act2_cnt, STARTUP + LEN * CPB2); end
      checks++;
      if (hold2_cnt != LEN * (RL2 + 1)) begin errors++; $display("FAIL rl2_addr_hold: got %0d, want %0d", hold2_cnt, LEN * (RL2 + 1)); end
      bad_r = (rd2_c.size() == LEN) ? 0 : 1;
      for (int k = 0; k < rd2_c.size() && k < LEN; k++)
         if (rd2_c[k] != t + STARTUP + k * CPB2 || rd2_a[k] !== {8'h42, 8'(k)}) bad_r++;
      checks++;
      if (bad_r != 0) begin errors++; $display("FAIL rl2_reads: got %0d bad of %0d, want 0", bad_r, rd2_c.size()); end
      bad_w = (wr2_c.size() == LEN) ? 0 : 1;
      for (int k = 0; k < wr2_c.size() && k < LEN; k++)
         if (wr2_c[k] != t + STARTUP + k * CPB2 + CPB2 - 1 || wr2_i[k] !== 8'(k) || wr2_d[k] !== (8'(k) ^ 8'h5A)) bad_w++;
      checks++;
      if (bad_w != 0) begin errors++; $display("FAIL rl2_writes: got %0d bad of %0d, want 0", bad_w, wr2_c.size()); end
      checks++;
      if (act_cnt != 0) begin errors++; $display("FAIL rl2_dut1_idle: got %0d active clocks, want 0", act_cnt); end
   endtask

   task automatic test_reset_mid();
      int t, n, d;
      clear_logs();
      cpu_write(8'($urandom_range(1, 255)), t);
      n = 0;
      while (wr_i.size() < 37 && n < 1000) begin step(1); n++; end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({d1_dma_reg, d1_active, d1_cpu_block, d1_rd_req, d1_bus_addr, d1_oam_we, d1_oam_addr, d1_oam_data} !== 44'h0) begin
         errors++; $display("FAIL reset_mid_async: got active=%b rd=%b addr=%h reg=%h, want all 0", d1_active, d1_rd_req, d1_bus_addr, d1_dma_reg);
      end
      step(3);
      rst_n = 1'b1;
      step(100);
      checks++;
      if (wr_i.size() != 37) begin errors++; $display("FAIL reset_mid_writes: got %0d writes, want 37", wr_i.size()); end
      checks++;
      if (d1_active !== 1'b0 || d1_dma_reg !== 8'h00) begin errors++; $display("FAIL reset_mid_idle: got active=%b reg=%h, want 0 00", d1_active, d1_dma_reg); end
      clear_logs();
      cpu_write(8'hD7, t);
      wait_idle1();
      build_expect();
      d = log_diff();
      checks++;
      if (d != 0 || act_cnt != STARTUP + LEN * CPB) begin errors++; $display("FAIL reset_mid_resume: diffs=%0d active=%0d, want 0 and %0d", d, act_cnt, STARTUP + LEN * CPB); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_echo();
      test_random_pages();
      test_restart();
      test_coincident();
      test_bus_block();
      test_timing_rl2();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/oam_dma_controller.md
Name: oam_dma_controller

Overview:
- Sequences the OAM DMA transfer triggered by a CPU write to FF46: copies DMA_LENGTH bytes from {FF46, 8'h00} into sprite OAM (FE00-FE9F), one byte per CYCLES_PER_BYTE clocks.
- Sits beside the mmu. It drives a source-read request into the mmu read mux and a dedicated OAM write port.
- While a transfer is active, it tells the mmu to block CPU bus accesses outside high RAM.

Parameters:
- DMA_LENGTH, 160: bytes per transfer; OAM index 0..DMA_LENGTH-1.
- CYCLES_PER_BYTE, 4: clocks spent per byte; must be >= READ_LATENCY+2.
- READ_LATENCY, 1: clocks from oBusAddr valid to iBusData valid.
- STARTUP_CYCLES, 4: clocks between the FF46 write and the first source read; must be >= 1.

Ports:
- iClock, input, 1: system clock; all state changes on the rising edge.
- iReset, input, 1: asynchronous, active-low reset.
- iCpuAddr, input, 16: CPU address.
- iCpuWe, input, 1: CPU write strobe.
- iCpuData, input, 8: CPU write data.
- oDmaReg, output, 8: FF46 readback value.
- oDmaActive, output, 1: transfer in progress (startup or transfer phase).
- oCpuBusBlock, output, 1: mmu must return 8'hFF on CPU reads and drop CPU writes.
- oBusReadRequest, output, 1: source read strobe to the mmu.
- oBusAddr, output, 16: source address.
- iBusData, input, 8: source read data from the mmu.
- oOamWe, output, 1: OAM write enable.
- oOamAddr, output, 8: OAM index.
- oOamData, output, 8: OAM write data.

Behaviour:
- Reset (iReset=0, asynchronous): every output is 0, the FSM goes to IDLE, and all counters and the data register clear. If reset lands mid-transfer, OAM bytes already written stay untouched and no further write occurs.
- Trigger: a rising edge with iCpuWe=1 and iCpuAddr=16'hFF46.
  - oDmaReg <= iCpuData.
  - Source page <= iCpuData, except values >= 8'hE0 map to iCpuData & 8'hDF (echo to work RAM, e.g. E3 -> C3, FE -> DE).
  - FSM enters DELAY.
  - The trigger is accepted in any state and is never blocked.
- FSM states: IDLE -> DELAY -> XFER -> IDLE.
- IDLE: oDmaActive=0, all strobes low.
- DELAY: oDmaActive=1 and strobes low for exactly STARTUP_CYCLES clocks, then XFER with index=0, phase=0.
- XFER, per byte (phase 0..CYCLES_PER_BYTE-1):
  - Phase 0: oBusReadRequest=1.
  - Phases 0..READ_LATENCY: oBusAddr={page, index[7:0]}, held stable.
  - End of phase READ_LATENCY: iBusData is captured into the data register.
  - Phase CYCLES_PER_BYTE-1: oOamWe=1, oOamAddr=index, oOamData=captured byte.
  - After the last phase: index increments and phase returns to 0.
  - After the last phase of index DMA_LENGTH-1: IDLE, and oDmaActive falls on that edge.
- Total active duration: STARTUP_CYCLES + DMA_LENGTH*CYCLES_PER_BYTE clocks. With defaults this is 644.
- oBusAddr and oOamAddr are 0 whenever their strobe is not valid in the current phase. The index counter is 8 bits and never wraps past DMA_LENGTH-1.
- Restart: a trigger during DELAY or XFER reloads the page, index=0 and phase=0, and re-enters DELAY.
  - oDmaActive stays high throughout the restart.
  - Any partially fetched byte is discarded; no OAM write occurs for it.
  - A trigger coincident with the final write still suppresses that write, then restarts.
- oCpuBusBlock = oDmaActive && !(iCpuAddr in FF80..FFFE) && iCpuAddr != FF46. It is combinational from the address and registered state.
- oDmaReg holds its value after completion and is unaffected by the transfer.

Test Plan:
- Reset: iReset=0 asserted mid-XFER at index 37 -> all outputs read 0 immediately without a clock edge; after release, no oOamWe pulses until a new FF46 write.
- Basic transfer: write 8'hC1 to FF46, bench memory returns addr[7:0]^8'h5A.
  - Reads cover C100..C19F in order.
  - 160 oOamWe pulses with oOamAddr 0..159 and oOamData = idx^8'h5A.
  - First read 4 clocks after the trigger edge.
  - oDmaActive high for exactly 644 clocks; oDmaReg = 8'hC1.
- Echo mapping: write 8'hE3 -> first oBusAddr = 16'hC300; write 8'hFE -> 16'hDE00; oDmaReg reads back E3/FE unchanged.
- Restart: FF46=8'hC0, then FF46=8'h80 during phase 2 of index 50.
  - No OAM write for index 50 from C0.
  - After 4 clocks reads restart at 8000, OAM index 0.
  - oDmaActive never drops; total active = 644 clocks after the second write.
- Bus block during XFER:
  - iCpuAddr = FF85 -> 0.
  - FFFE -> 0.
  - FF46 -> 0.
  - C000 -> 1.
  - FFFF -> 1.
  - FE00 -> 1.
  - After completion, any address -> 0.
- Timing with READ_LATENCY=2, CYCLES_PER_BYTE=5: oBusAddr is held for phases 0..2, data is captured at the end of phase 2, oOamWe is asserted in phase 4, and total active = 804 clocks.
